// File: rtl/ifu_mem_responder_pkg.sv
// ifu_mem_responder_pkg
//   Shared constants for the instruction-fetch memory responder:
//   FSM state encoding, error-response data word, LFSR seed/taps and
//   an index-width helper.
//   Optional feature macro: IFU_MEM_RSP_RAND_DELAY_EN (random extra latency).
package ifu_mem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] ERR_DATA = 32'h0000_0000;

    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register:
    // feedback is the XOR of bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ifu_mem_lfsr8.sv
// ifu_mem_lfsr8
//   8-bit Fibonacci LFSR used to add a pseudo-random extra latency to
//   fetch responses. Advances once per cycle while en=1.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset, loads LFSR_SEED
//     en   - advance strobe
//     q    - current register value
//   Only instantiated when IFU_MEM_RSP_RAND_DELAY_EN is defined.
module ifu_mem_lfsr8
    import ifu_mem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    logic fb;

    assign fb = ^(q & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/ifu_mem_responder.sv
// ifu_mem_responder
//   Memory-side model of the instruction-fetch bus. Accepts one fetch at a
//   time, waits a programmable latency, then returns the addressed word
//   with a single-cycle rvalid pulse. Holds a word-addressed array that is
//   preloaded through an independent write port.
//   Ports:
//     clk, rst           - clock, synchronous active-high reset
//     arvalid, araddr    - fetch request and byte address
//     arready            - high in IDLE (and not in reset)
//     rdata, rvalid, rerr- response word, one-cycle pulse, out-of-range flag
//     wr_en, wr_addr,
//     wr_data            - preload write port (out-of-range writes dropped)
//   Optional feature: define IFU_MEM_RSP_RAND_DELAY_EN to add 0..3 extra
//   cycles of latency drawn from an 8-bit LFSR at each acceptance.
//
//   state | meaning
//   IDLE  | arready=1, waiting for arvalid
//   WAIT  | request latched, latency counter running down
//   RESP  | rvalid=1 for this single cycle
module ifu_mem_responder
    import ifu_mem_responder_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 1024,
    parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
    parameter int                LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arvalid,
    input  logic [ADDR_W-1:0] araddr,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rerr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int                IDX_W = clog2(DEPTH);
    localparam int                CNT_W = 8;
    localparam logic [ADDR_W:0]   SPAN  = (ADDR_W+1)'(DEPTH * 4);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] off;
        off = {1'b0, a} - {1'b0, BASE};
        return (a >= BASE) && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE;
        return off[IDX_W+1:2];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_err;
    logic             accept;
    logic [1:0]       extra;
    logic [CNT_W-1:0] lat_eff;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_err;

    assign arready = (state == ST_IDLE) && !rst;
    assign accept  = arvalid && arready;
    assign rvalid  = (state == ST_RESP);

`ifdef IFU_MEM_RSP_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    ifu_mem_lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .q   (lfsr_q)
    );

    // Sampled before the LFSR advances on the same acceptance edge.
    assign extra = lfsr_q[1:0];
`else
    assign extra = 2'd0;
`endif

    assign lat_eff = CNT_W'(LATENCY) + {{(CNT_W-2){1'b0}}, extra};

    // With an effective latency of 1 the capture happens at the acceptance
    // edge itself, so the live address is the "latched" one.
    always_comb begin
        cap_idx = lat_idx;
        cap_err = lat_err;
        if (state == ST_IDLE) begin
            cap_idx = to_index(araddr);
            cap_err = !in_range(araddr);
        end
    end

    // Nonblocking array update gives read-before-write when a preload write
    // hits the captured index on the capture edge.
    always_ff @(posedge clk) begin
        if (wr_en && in_range(wr_addr)) begin
            mem[to_index(wr_addr)] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            lat_idx <= '0;
            lat_err <= 1'b0;
            rdata   <= '0;
            rerr    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_idx <= to_index(araddr);
                        lat_err <= !in_range(araddr);
                        if (lat_eff == CNT_W'(1)) begin
                            state <= ST_RESP;
                            rerr  <= cap_err;
                            rdata <= cap_err ? DATA_W'(ERR_DATA) : mem[cap_idx];
                        end else begin
                            cnt   <= lat_eff - CNT_W'(2);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                        rerr  <= cap_err;
                        rdata <= cap_err ? DATA_W'(ERR_DATA) : mem[cap_idx];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_mem_responder.sv
module tb_ifu_mem_responder;

    localparam int          ADDR_W  = 32;
    localparam int          DATA_W  = 32;
    localparam int          DEPTH   = 1024;
    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int          LATENCY = 2;

    logic              clk;
    logic              rst;
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rerr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    int checks;
    int errors;

    logic [31:0] mem_m [DEPTH];
    logic [7:0]  lfsr_m;

    ifu_mem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .BASE   (BASE),
        .LATENCY(LATENCY)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arvalid(arvalid),
        .araddr (araddr),
        .arready(arready),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rerr   (rerr),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit addr_ok(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < DEPTH * 4);
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    function automatic int next_latency();
        int l;
        l = LATENCY;
`ifdef IFU_MEM_RSP_RAND_DELAY_EN
        l = l + int'(lfsr_m[1:0]);
`endif
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        return l;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        if (addr_ok(a)) mem_m[addr_idx(a)] = d;
    endtask

    // One fetch. wr_k >= 0 drives a write of wdat to the same address on
    // edge wr_k counted from the acceptance edge (0).
    task automatic do_request(input logic [31:0] a, input int wr_k,
                              input logic [31:0] wdat, input string name);
        int          leff;
        int          n;
        bit          seen;
        logic [31:0] exp_d;
        logic        exp_e;
        leff = next_latency();
        exp_e = !addr_ok(a);
        if (wr_k >= 0 && wr_k < leff - 1 && addr_ok(a)) mem_m[addr_idx(a)] = wdat;
        exp_d = exp_e ? 32'h0 : mem_m[addr_idx(a)];
        if (wr_k >= 0 && wr_k == leff - 1 && addr_ok(a)) mem_m[addr_idx(a)] = wdat;

        arvalid = 1'b1; araddr = a;
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL %s arready_idle: got %b expected 1", name, arready);
        end
        wr_en = (wr_k == 0); wr_addr = a; wr_data = wdat;
        step();
        arvalid = 1'b0; araddr = $urandom; wr_en = 1'b0;

        n = 0; seen = 0;
        for (int j = 0; j < 12 && !seen; j++) begin
            if (rvalid === 1'b1) begin
                seen = 1;
            end else begin
                checks++;
                if (arready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s arready_wait: got %b expected 0", name, arready);
                end
                wr_en = (wr_k == n + 1);
                step();
                wr_en = 1'b0;
                n++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: got no rvalid expected rvalid after %0d edges", name, leff - 1);
        end else begin
            if (n != leff - 1) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, n, leff - 1);
            end
            checks++;
            if (rdata !== exp_d) begin
                errors++;
                $display("FAIL %s rdata: got %h expected %h", name, rdata, exp_d);
            end
            checks++;
            if (rerr !== exp_e) begin
                errors++;
                $display("FAIL %s rerr: got %b expected %b", name, rerr, exp_e);
            end
            checks++;
            if (arready !== 1'b0) begin
                errors++;
                $display("FAIL %s arready_resp: got %b expected 0", name, arready);
            end
            step();
            checks++;
            if (rvalid !== 1'b0 || arready !== 1'b1) begin
                errors++;
                $display("FAIL %s after_pulse: got rvalid=%b arready=%b expected 0/1",
                         name, rvalid, arready);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; arvalid = 1'b0; araddr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        lfsr_m = 8'hA5;
        step(); step();
        checks++;
        if (rvalid !== 1'b0 || rerr !== 1'b0 || rdata !== 32'h0 || arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rvalid=%b rerr=%b rdata=%h arready=%b expected 0/0/0/0",
                     rvalid, rerr, rdata, arready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_arready: got %b expected 1", arready);
        end
    endtask

    task automatic test_preload();
        for (int i = 0; i < DEPTH; i++) begin
            do_write(BASE + 32'(i * 4), 32'h1000_0000 ^ (32'(i) * 32'h9E37_79B1));
        end
        do_write(32'h8000_0000, 32'h0000_0413);
        do_write(32'h8000_0004, 32'h0010_0093);
        do_write(32'h8000_0008, 32'h1111_1111);
        do_request(32'h8000_0000, -1, 32'h0, "fetch_word0");
        do_request(32'h8000_0007, -1, 32'h0, "fetch_low_bits_ignored");
        do_request(32'h8000_0FFC, -1, 32'h0, "fetch_last_word");
    endtask

    task automatic test_back_to_back();
        int          l1, l2, acc, nrv, cyc;
        int          rv_cyc [2];
        logic [31:0] rv_dat [2];
        bit          acc_now;
        l1 = next_latency();
        l2 = next_latency();
        arvalid = 1'b1; araddr = 32'h8000_0000;
        acc = 0; nrv = 0; cyc = 0;
        for (int c = 0; c < 24; c++) begin
            if (rvalid === 1'b1) begin
                if (nrv < 2) begin
                    rv_cyc[nrv] = cyc;
                    rv_dat[nrv] = rdata;
                end
                nrv++;
            end
            acc_now = arvalid && (arready === 1'b1);
            step();
            cyc++;
            if (acc_now) begin
                acc++;
                if (acc == 1) araddr = 32'h8000_0004;
                if (acc == 2) arvalid = 1'b0;
            end
        end
        arvalid = 1'b0;
        checks++;
        if (nrv != 2 || acc != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses %0d accepts expected 2/2", nrv, acc);
        end else begin
            checks++;
            if (rv_dat[0] !== mem_m[0] || rv_dat[1] !== mem_m[1]) begin
                errors++;
                $display("FAIL b2b_data: got %h %h expected %h %h",
                         rv_dat[0], rv_dat[1], mem_m[0], mem_m[1]);
            end
            checks++;
            if (rv_cyc[0] != l1 || rv_cyc[1] - rv_cyc[0] != l2 + 1) begin
                errors++;
                $display("FAIL b2b_timing: got first=%0d spacing=%0d expected %0d/%0d",
                         rv_cyc[0], rv_cyc[1] - rv_cyc[0], l1, l2 + 1);
            end
        end
    endtask

    task automatic test_out_of_range();
        do_request(32'h7FFF_FFFC, -1, 32'h0, "oor_below");
        do_request(32'h8000_1000, -1, 32'h0, "oor_above");
        do_request(32'h0000_0000, -1, 32'h0, "oor_zero");
        do_write(32'h8000_1000, 32'hDEAD_BEEF);
        do_write(32'h7FFF_FFFC, 32'hCAFE_F00D);
        do_request(32'h8000_0000, -1, 32'h0, "oor_write_dropped_lo");
        do_request(32'h8000_0FFC, -1, 32'h0, "oor_write_dropped_hi");
    endtask

    task automatic test_collision();
        // Write on the capture edge returns the old word; a write on the
        // acceptance edge (one earlier) is visible.
        do_request(32'h8000_0008, LATENCY - 1, 32'h2222_2222, "collide_capture_edge");
        do_write(32'h8000_0008, 32'h1111_1111);
        do_request(32'h8000_0008, LATENCY - 2, 32'h2222_2222, "collide_earlier_edge");
        do_request(32'h8000_0008, -1, 32'h0, "collide_readback");
    endtask

    task automatic test_reset_abort();
        int leff;
        bit bad;
        leff = next_latency();
        arvalid = 1'b1; araddr = 32'h8000_0004;
        step();
        arvalid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b0) begin
            errors++;
            $display("FAIL abort_arready_in_rst: got %b expected 0", arready);
        end
        step();
        rst = 1'b0;
        lfsr_m = 8'hA5;
        #1;
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got arready=%b rvalid=%b expected 1/0", arready, rvalid);
        end
        bad = 0;
        for (int i = 0; i < leff + 4; i++) begin
            if (rvalid !== 1'b0) bad = 1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_no_rvalid: got rvalid=1 expected none after %0d-cycle request", leff);
        end
        do_request(32'h8000_0004, -1, 32'h0, "abort_recover");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          kind;
        int          wk;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(BASE + 32'($urandom_range(0, DEPTH - 1) * 4), $urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0)      a = $urandom & 32'h7FFF_FFFF;
            else if (kind == 1) a = 32'h8000_1000 + 32'($urandom_range(0, 32'hFFFF));
            else                a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            wk = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, LATENCY - 1)) : -1;
            do_request(a, wk, $urandom, $sformatf("random_%0d", i));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_preload();
        test_back_to_back();
        test_out_of_range();
        test_collision();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
